booth8_seq: RTL and testbench

Sequential radix-8 Booth multiplier core. It sits between the operand memories and the result memory of the multiplier datapath. It samples signed operands from the A and B memory read ports and forms the full-width signed product one Booth digit per cycle. It writes the low word to the C memory (C_In/C_En) and exposes the full product and an overflow flag.

---
 rtl/booth_pkg.sv | 23 ++
 rtl/booth8_digit.sv | 51 +++++
 rtl/booth8_seq.sv | 131 +++++++++++++
 tb/tb_booth8_seq.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/booth_pkg.sv
// Shared definitions for the sequential radix-8 Booth multiplier:
// FSM state encoding, digit-count helper and recoder magnitude codes.
package booth_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_ITER = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  // Magnitude of a radix-8 Booth digit; the sign is carried separately.
  localparam logic [2:0] MAG_ZERO  = 3'd0;
  localparam logic [2:0] MAG_ONE   = 3'd1;
  localparam logic [2:0] MAG_TWO   = 3'd2;
  localparam logic [2:0] MAG_THREE = 3'd3;
  localparam logic [2:0] MAG_FOUR  = 3'd4;

  function automatic int digitCount(input int m);
    return (m + 2) / 3;
  endfunction

endpackage

// File: rtl/booth8_digit.sv
// Combinational radix-8 Booth recoder: turns four overlapping multiplier bits
// into the signed partial term d*A, with d in -4..+4.
module booth8_digit
  import booth_pkg::*;
#(
  parameter int N = 8
) (
  input  logic [3:0]   i_Bits,
  input  logic [N:0]   i_Aq,
  input  logic [N+2:0] i_A3q,
  output logic [N+3:0] o_Term
);

  logic [2:0]   w_Mag;
  logic         w_Neg;
  logic [N+3:0] w_ASext;
  logic [N+3:0] w_Sel;

  assign w_ASext = {{3{i_Aq[N]}}, i_Aq};

  // Digit value is -4*b3 + 2*b2 + b1 + b0, split into magnitude and sign.
  always_comb begin
    w_Mag = MAG_ZERO;
    w_Neg = 1'b0;
    case (i_Bits)
      4'b0001, 4'b0010: w_Mag = MAG_ONE;
      4'b0011, 4'b0100: w_Mag = MAG_TWO;
      4'b0101, 4'b0110: w_Mag = MAG_THREE;
      4'b0111:          w_Mag = MAG_FOUR;
      4'b1000:          begin w_Mag = MAG_FOUR;  w_Neg = 1'b1; end
      4'b1001, 4'b1010: begin w_Mag = MAG_THREE; w_Neg = 1'b1; end
      4'b1011, 4'b1100: begin w_Mag = MAG_TWO;   w_Neg = 1'b1; end
      4'b1101, 4'b1110: begin w_Mag = MAG_ONE;   w_Neg = 1'b1; end
      default:          w_Mag = MAG_ZERO;
    endcase
  end

  always_comb begin
    w_Sel = '0;
    case (w_Mag)
      MAG_ONE:   w_Sel = w_ASext;
      MAG_TWO:   w_Sel = w_ASext << 1;
      MAG_THREE: w_Sel = {i_A3q[N+2], i_A3q};
      MAG_FOUR:  w_Sel = w_ASext << 2;
      default:   w_Sel = '0;
    endcase
  end

  assign o_Term = w_Neg ? -w_Sel : w_Sel;

endmodule

// File: rtl/booth8_seq.sv
// Sequential radix-8 Booth multiplier: one Booth digit per cycle, full-width
// signed product, low word written to C memory with an overflow flag.
module booth8_seq
  import booth_pkg::*;
#(
  parameter int N = 8
) (
  input  logic             i_Clock,
  input  logic             i_Reset_n,
  input  logic             i_Start,
  input  logic [N:0]       i_A_Out,
  input  logic [N:0]       i_B_Out,
  output logic             o_Busy,
  output logic             o_Done,
  output logic [2*N+1:0]   o_Prod,
  output logic [N:0]       o_C_In,
  output logic             o_C_En,
  output logic             o_Ovf
);

  localparam int M  = N + 1;
  localparam int K  = digitCount(M);
  localparam int BW = 3 * K;
  localparam int PW = 2 * M;
  localparam int CW = (K > 1) ? $clog2(K) : 1;
  localparam int SW = $clog2(BW) + 1;

  state_e               r_State;
  logic [CW-1:0]        r_Cnt;
  logic [SW-1:0]        r_Shift;
  logic [M-1:0]         r_Aq;
  logic [M+1:0]         r_A3q;
  logic signed [BW-1:0] r_Bq;
  logic                 r_BLow;
  logic [PW-1:0]        r_Acc;
  logic [PW-1:0]        r_Prod;
  logic                 r_Busy;
  logic                 r_Done;
  logic                 r_CEn;
  logic                 r_Ovf;

  logic [M+1:0]         w_ASext;
  logic [M+2:0]         w_Term;
  logic [PW-1:0]        w_TermExt;
  logic [PW-1:0]        w_AccNext;
  logic [M:0]           w_Upper;
  logic                 w_OvfNext;
  logic                 w_Last;

  booth8_digit #(.N(N)) u_digit (
    .i_Bits (({r_Bq[2:0], r_BLow})),
    .i_Aq   (r_Aq),
    .i_A3q  (r_A3q),
    .o_Term (w_Term)
  );

  assign w_ASext   = {i_A_Out[M-1], i_A_Out[M-1], i_A_Out};
  assign w_TermExt = {{(PW-M-3){w_Term[M+2]}}, w_Term};
  assign w_AccNext = r_Acc + (w_TermExt << r_Shift);
  assign w_Last    = (r_Cnt == CW'(K - 1));

  // The product fits in M signed bits only if its top M+1 bits are all equal.
  assign w_Upper   = w_AccNext[PW-1:M-1];
  assign w_OvfNext = !((&w_Upper) || !(|w_Upper));

  // B is kept as an arithmetic shift register so the current digit always
  // sits in the low three bits, with the previous top bit held in r_BLow.
  always_ff @(posedge i_Clock) begin
    if (!i_Reset_n) begin
      r_State <= ST_IDLE;
      r_Cnt   <= '0;
      r_Shift <= '0;
      r_Aq    <= '0;
      r_A3q   <= '0;
      r_Bq    <= '0;
      r_BLow  <= 1'b0;
      r_Acc   <= '0;
      r_Prod  <= '0;
      r_Busy  <= 1'b0;
      r_Done  <= 1'b0;
      r_CEn   <= 1'b0;
      r_Ovf   <= 1'b0;
    end else begin
      r_Done <= 1'b0;
      r_CEn  <= 1'b0;
      case (r_State)
        ST_IDLE: begin
          if (i_Start) begin
            r_State <= ST_LOAD;
            r_Busy  <= 1'b1;
          end
        end
        ST_LOAD: begin
          r_Aq    <= i_A_Out;
          r_A3q   <= w_ASext + {w_ASext[M:0], 1'b0};
          r_Bq    <= BW'($signed(i_B_Out));
          r_BLow  <= 1'b0;
          r_Acc   <= '0;
          r_Cnt   <= '0;
          r_Shift <= '0;
          r_State <= ST_ITER;
        end
        ST_ITER: begin
          r_Acc   <= w_AccNext;
          r_Bq    <= r_Bq >>> 3;
          r_BLow  <= r_Bq[2];
          r_Cnt   <= r_Cnt + 1'b1;
          r_Shift <= r_Shift + SW'(3);
          if (w_Last) begin
            r_Prod  <= w_AccNext;
            r_Ovf   <= w_OvfNext;
            r_Busy  <= 1'b0;
            r_Done  <= 1'b1;
            r_CEn   <= 1'b1;
            r_State <= ST_DONE;
          end
        end
        ST_DONE: r_State <= ST_IDLE;
        default: r_State <= ST_IDLE;
      endcase
    end
  end

  assign o_Busy = r_Busy;
  assign o_Done = r_Done;
  assign o_Prod = r_Prod;
  assign o_C_In = r_Prod[M-1:0];
  assign o_C_En = r_CEn;
  assign o_Ovf  = r_Ovf;

endmodule

// File: tb/tb_booth8_seq.sv
// Scoreboard bench for booth8_seq: the driver queues the signed product of each
// accepted request, the monitor checks every Done/C_En pulse against it.
module tb_booth8_seq;

  localparam int N   = 8;
  localparam int K   = 3;
  localparam int LAT = K + 2;

  logic        clk   = 1'b0;
  logic        rstN  = 1'b0;
  logic        start = 1'b0;
  logic [8:0]  aOut  = '0;
  logic [8:0]  bOut  = '0;
  logic        busy, done, cEn, ovf;
  logic [17:0] prod;
  logic [8:0]  cIn;

  typedef struct {
    logic [17:0] prod;
    logic        ovf;
    int          stamp;
  } exp_t;

  exp_t sbQ[$];
  exp_t monE;
  int   checks     = 0;
  int   failures   = 0;
  int   cycleCount = 0;
  int   doneCount  = 0;
  int   issued     = 0;

  booth8_seq #(.N(N)) dut (
    .i_Clock   (clk),
    .i_Reset_n (rstN),
    .i_Start   (start),
    .i_A_Out   (aOut),
    .i_B_Out   (bOut),
    .o_Busy    (busy),
    .o_Done    (done),
    .o_Prod    (prod),
    .o_C_In    (cIn),
    .o_C_En    (cEn),
    .o_Ovf     (ovf)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycleCount++;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Plain signed multiply; overflow means the product leaves the 9-bit signed range.
  function automatic exp_t refModel(input logic [8:0] a, input logic [8:0] b, input int stamp);
    exp_t r;
    int   pa, pb, p;
    pa = $signed(a);
    pb = $signed(b);
    p  = pa * pb;
    r.prod  = p[17:0];
    r.ovf   = (p > 255) || (p < -256);
    r.stamp = stamp;
    return r;
  endfunction

  function automatic logic [8:0] pickVal();
    case ($urandom_range(0, 7))
      0:       return 9'h100;
      1:       return 9'h0FF;
      2:       return 9'h1FF;
      3:       return 9'h000;
      default: return 9'($urandom_range(0, 511));
    endcase
  endfunction

  task automatic checkZero(input string tag);
    checkOutput({tag, "_prod"}, 32'(prod), 0);
    checkOutput({tag, "_cin"},  32'(cIn),  0);
    checkOutput({tag, "_ovf"},  32'(ovf),  0);
    checkOutput({tag, "_busy"}, 32'(busy), 0);
    checkOutput({tag, "_done"}, 32'(done), 0);
    checkOutput({tag, "_cen"},  32'(cEn),  0);
  endtask

  // Called at a negedge with the DUT idle; returns six negedges later, the
  // earliest point a new request can be accepted. With pokeStart, Start is
  // also raised during ITER and DONE, where it must be ignored.
  task automatic applyStimulus(input logic [8:0] a, input logic [8:0] b, input bit pokeStart);
    aOut  = a;
    bOut  = b;
    start = 1'b1;
    sbQ.push_back(refModel(a, b, cycleCount + 1));
    issued++;
    @(negedge clk);
    start = 1'b0;
    checkOutput("busy_load", 32'(busy), 1);
    @(negedge clk);
    aOut  = 9'($urandom_range(0, 511));
    bOut  = 9'($urandom_range(0, 511));
    start = pokeStart;
    @(negedge clk);
    aOut  = 9'($urandom_range(0, 511));
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    start = pokeStart;
    @(negedge clk);
    start = 1'b0;
  endtask

  always @(negedge clk) begin
    if (done === 1'b1 || cEn === 1'b1) begin
      doneCount++;
      if (sbQ.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL unexpected_done: done=%0b c_en=%0b, expected no completion", done, cEn);
      end else begin
        monE = sbQ.pop_front();
        checkOutput("prod",    32'(prod), 32'(monE.prod));
        checkOutput("c_in",    32'(cIn),  32'(monE.prod[8:0]));
        checkOutput("ovf",     32'(ovf),  32'(monE.ovf));
        checkOutput("done",    32'(done), 1);
        checkOutput("c_en",    32'(cEn),  1);
        checkOutput("busy_done", 32'(busy), 0);
        // Done is sampled by the fifth edge after the edge that took Start.
        checkOutput("latency", 32'(cycleCount - monE.stamp + 1), LAT);
      end
    end
  end

  initial begin
    $display("[TB] booth8_seq scoreboard run");
    rstN  = 1'b0;
    start = 1'b1;
    aOut  = 9'h0AB;
    bOut  = 9'h155;
    repeat (2) begin
      @(posedge clk);
      @(negedge clk);
      checkZero("reset");
    end
    start = 1'b0;
    rstN  = 1'b1;
    @(negedge clk);

    applyStimulus(9'd7, 9'd5, 1'b0);
    checkOutput("p7x5_prod", 32'(prod), 32'd35);
    checkOutput("p7x5_ovf",  32'(ovf),  0);
    applyStimulus(9'h100, 9'h100, 1'b0);
    checkOutput("pm256sq_prod", 32'(prod), 32'h10000);
    checkOutput("pm256sq_cin",  32'(cIn),  32'h000);
    checkOutput("pm256sq_ovf",  32'(ovf),  1);
    applyStimulus(9'h0FF, 9'h1FF, 1'b0);
    checkOutput("p255xm1_prod", 32'(prod), 32'h3FF01);
    checkOutput("p255xm1_cin",  32'(cIn),  32'h101);
    checkOutput("p255xm1_ovf",  32'(ovf),  0);
    applyStimulus(9'h000, 9'h100, 1'b0);
    checkOutput("p0xm256_prod", 32'(prod), 0);
    checkOutput("p0xm256_ovf",  32'(ovf),  0);
    applyStimulus(9'h100, 9'h0FF, 1'b0);
    applyStimulus(9'h0FF, 9'h0FF, 1'b0);
    applyStimulus(9'h1FF, 9'h1FF, 1'b0);
    applyStimulus(9'h100, 9'h001, 1'b0);

    applyStimulus(9'h0AA, 9'h13C, 1'b1);
    repeat (2) @(negedge clk);
    checkOutput("ignored_start_count", 32'(doneCount), 32'(issued));

    // Abort mid-ITER: the pending result is dropped and no C_En may follow.
    aOut  = 9'h0C3;
    bOut  = 9'h1A7;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rstN = 1'b0;
    @(negedge clk);
    checkZero("abort");
    rstN = 1'b1;
    repeat (6) @(negedge clk);
    checkOutput("abort_done_count", 32'(doneCount), 32'(issued));
    applyStimulus(9'h013, 9'h1F0, 1'b0);

    for (int i = 0; i < 1500; i++) begin
      applyStimulus(pickVal(), pickVal(), (i % 50) == 7);
    end

    repeat (8) @(negedge clk);
    checkOutput("queue_empty", 32'(sbQ.size()), 0);
    checkOutput("done_count_final", 32'(doneCount), 32'(issued));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
